// File: rtl/wb_boot_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : wb_boot_ctrl
// Brief    : Wishbone-controlled warm-boot sequencer: USB detach delay, then
//            drives the iCE40 SB_WARMBOOT BOOT/S1/S0 inputs.
// Revision : 1.0 - initial release
//==============================================================================
module wb_boot_ctrl #(
    parameter int          TIMER_WIDTH   = 24,
    parameter int          DEFAULT_DELAY = 2400000,
    parameter logic [7:0]  MAGIC         = 8'hB0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  wb_addr,
    output logic [31:0] wb_rdata,
    input  logic [31:0] wb_wdata,
    input  logic        wb_we,
    input  logic        wb_cyc,
    output logic        wb_ack,
    output logic        usb_detach,
    output logic        boot,
    output logic [1:0]  boot_sel,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DETACH = 2'd1,
        ST_BOOT   = 2'd2
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] c_default_delay = TIMER_WIDTH'(DEFAULT_DELAY);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TIMER_WIDTH-1:0]  r_counter;
    logic [TIMER_WIDTH-1:0]  w_counter_nxt;
    logic [TIMER_WIDTH-1:0]  r_delay;
    logic                    r_usb_detach;
    logic                    w_usb_detach_nxt;
    logic                    r_boot;
    logic                    w_boot_nxt;
    logic [1:0]              r_boot_sel;
    logic [1:0]              w_boot_sel_nxt;
    logic                    r_ack;
    logic [31:0]             r_rdata;
    logic [31:0]             w_rdata;
    logic                    w_wr;
    logic                    w_ctrl_ok;
    logic                    w_go;
    logic                    w_busy;
    logic                    w_unused;

    // Writes commit on the ack cycle so each transaction acts exactly once.
    assign w_wr      = wb_cyc & wb_we & r_ack;
    assign w_ctrl_ok = w_wr & (wb_addr == 2'd0) & (wb_wdata[15:8] == MAGIC);
    assign w_go      = wb_wdata[2];
    assign w_busy    = (r_state != ST_IDLE);
    assign w_unused  = ^{wb_wdata[31:16], wb_wdata[7:3]};

    always_comb begin
        w_rdata = '0;
        case (wb_addr)
            2'd0: begin
                w_rdata[31]    = w_busy;
                w_rdata[17:16] = r_state;
                w_rdata[1:0]   = r_boot_sel;
            end
            2'd1:    w_rdata[TIMER_WIDTH-1:0] = r_delay;
            2'd2:    w_rdata[TIMER_WIDTH-1:0] = r_counter;
            default: w_rdata = '0;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_counter_nxt    = r_counter;
        w_usb_detach_nxt = r_usb_detach;
        w_boot_nxt       = r_boot;
        w_boot_sel_nxt   = r_boot_sel;
        case (r_state)
            ST_IDLE: begin
                if (w_ctrl_ok && w_go) begin
                    w_state_nxt      = ST_DETACH;
                    w_counter_nxt    = r_delay;
                    w_usb_detach_nxt = 1'b1;
                    w_boot_sel_nxt   = wb_wdata[1:0];
                end
            end
            ST_DETACH: begin
                // Abort takes priority over the terminal count.
                if (w_ctrl_ok && !w_go) begin
                    w_state_nxt      = ST_IDLE;
                    w_counter_nxt    = '0;
                    w_usb_detach_nxt = 1'b0;
                end else if (r_counter == '0) begin
                    w_state_nxt = ST_BOOT;
                    w_boot_nxt  = 1'b1;
                end else begin
                    w_counter_nxt = r_counter - 1'b1;
                end
            end
            ST_BOOT: begin
                w_boot_nxt       = 1'b1;
                w_usb_detach_nxt = 1'b1;
            end
            default: begin
                w_state_nxt      = ST_IDLE;
                w_counter_nxt    = '0;
                w_usb_detach_nxt = 1'b0;
                w_boot_nxt       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_counter    <= '0;
            r_usb_detach <= 1'b0;
            r_boot       <= 1'b0;
            r_boot_sel   <= 2'b00;
        end else begin
            r_state      <= w_state_nxt;
            r_counter    <= w_counter_nxt;
            r_usb_detach <= w_usb_detach_nxt;
            r_boot       <= w_boot_nxt;
            r_boot_sel   <= w_boot_sel_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack   <= 1'b0;
            r_rdata <= '0;
            r_delay <= c_default_delay;
        end else begin
            r_ack   <= wb_cyc & ~r_ack;
            r_rdata <= (wb_cyc & ~r_ack) ? w_rdata : 32'd0;
            if (w_wr && (wb_addr == 2'd1) && (r_state == ST_IDLE)) begin
                r_delay <= wb_wdata[TIMER_WIDTH-1:0];
            end
        end
    end

    assign wb_ack     = r_ack;
    assign wb_rdata   = r_rdata;
    assign usb_detach = r_usb_detach;
    assign boot       = r_boot;
    assign boot_sel   = r_boot_sel;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_wb_boot_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_wb_boot_ctrl
// Brief    : Self-checking bench for wb_boot_ctrl with a cycle-count model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_wb_boot_ctrl;

    localparam int unsigned DEF_DELAY = 2400000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  wb_addr = 2'd0;
    logic [31:0] wb_wdata = 32'd0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_rdata;
    logic        wb_ack;
    logic        usb_detach;
    logic        boot;
    logic [1:0]  boot_sel;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          hs_bad = 0;
    int          cyc_n  = 0;
    int unsigned m_delay = DEF_DELAY;
    logic [1:0]  m_sel   = 2'b00;

    wb_boot_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_addr    (wb_addr),
        .wb_rdata   (wb_rdata),
        .wb_wdata   (wb_wdata),
        .wb_we      (wb_we),
        .wb_cyc     (wb_cyc),
        .wb_ack     (wb_ack),
        .usb_detach (usb_detach),
        .boot       (boot),
        .boot_sel   (boot_sel),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [31:0] ctrl_word(input logic [7:0] key, input logic go, input logic [1:0] sel);
        return {16'h0, key, 5'h0, go, sel};
    endfunction

    // One transaction; returns at 1ns after the commit edge.
    task automatic bus(input logic [1:0] a, input logic we, input logic [31:0] d, output logic [31:0] rd);
        @(negedge clk);
        wb_addr = a; wb_we = we; wb_wdata = d; wb_cyc = 1'b1;
        if (wb_ack !== 1'b0) hs_bad++;
        @(posedge clk); #1;
        if (wb_ack !== 1'b1) hs_bad++;
        rd = wb_rdata;
        @(posedge clk); #1;
        if (wb_ack !== 1'b0 || wb_rdata !== 32'd0) hs_bad++;
        wb_cyc = 1'b0; wb_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        m_delay = DEF_DELAY;
        m_sel   = 2'b00;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        checks++;
        if ({wb_ack, usb_detach, boot, busy, boot_sel} !== 6'b0 || wb_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b det=%b boot=%b busy=%b sel=%b rdata=%h expected all zero",
                     wb_ack, usb_detach, boot, busy, boot_sel, wb_rdata);
        end
        bus(2'd0, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", rd, 32'd0); end
        bus(2'd1, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== DEF_DELAY) begin errors++; $display("FAIL reset_delay: got %0d expected %0d", rd, DEF_DELAY); end
        bus(2'd2, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected %h", rd, 32'd0); end
        checks++;
        if (hs_bad != 0) begin errors++; $display("FAIL reset_handshake: got %0d bad acks expected 0", hs_bad); end
    endtask

    // Program DELAY, fire go, and follow the sequence cycle by cycle.
    task automatic test_boot_seq(input int unsigned dly, input logic [1:0] sel);
        logic [31:0] rd;
        logic [4:0]  exp_v;
        bus(2'd1, 1'b1, dly, rd);
        m_delay = dly;
        bus(2'd0, 1'b1, ctrl_word(8'hB0, 1'b1, sel), rd);
        m_sel = sel;
        for (int k = 0; k <= int'(m_delay) + 1; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_v = {1'b1, (k == int'(m_delay) + 1), 1'b1, m_sel};
            checks++;
            if ({usb_detach, boot, busy, boot_sel} !== exp_v) begin
                errors++;
                $display("FAIL boot_seq d=%0d k=%0d: got det/boot/busy/sel=%b expected %b",
                         dly, k, {usb_detach, boot, busy, boot_sel}, exp_v);
            end
        end
        bus(2'd0, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== (32'h8002_0000 | 32'(m_sel))) begin
            errors++; $display("FAIL boot_ctrl_read: got %h expected %h", rd, 32'h8002_0000 | 32'(m_sel));
        end
        do_reset();
    endtask

    task automatic test_bad_key();
        logic [31:0] rd;
        logic [7:0]  key;
        key = 8'($urandom_range(0, 255));
        if (key == 8'hB0) key = 8'h00;
        bus(2'd0, 1'b1, ctrl_word(key, 1'b1, 2'($urandom_range(0, 3))), rd);
        repeat (2) @(posedge clk); #1;
        checks++;
        if ({busy, usb_detach, boot} !== 3'b000) begin
            errors++; $display("FAIL bad_key_state: got busy/det/boot=%b expected 000", {busy, usb_detach, boot});
        end
        bus(2'd0, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'(m_sel)) begin errors++; $display("FAIL bad_key_ctrl: got %h expected %h", rd, 32'(m_sel)); end
        bus(2'd3, 1'b1, 32'hFFFF_FFFF, rd);
        bus(2'd3, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL addr3_read: got %h expected 0", rd); end
        bus(2'd1, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== m_delay) begin errors++; $display("FAIL addr3_side_effect: got %0d expected %0d", rd, m_delay); end
    endtask

    task automatic test_detach_ignore_abort();
        logic [31:0] rd;
        int          c0;
        int          waits;
        int          boot_seen;
        bus(2'd1, 1'b1, 32'd100, rd);
        m_delay = 100;
        bus(2'd0, 1'b1, ctrl_word(8'hB0, 1'b1, 2'd1), rd);
        m_sel = 2'd1;
        c0 = cyc_n;
        bus(2'd1, 1'b1, 32'd7, rd);
        bus(2'd0, 1'b1, ctrl_word(8'hB0, 1'b1, 2'd3), rd);
        bus(2'd1, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'd100) begin errors++; $display("FAIL detach_delay_locked: got %0d expected 100", rd); end
        bus(2'd0, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'h8001_0001) begin errors++; $display("FAIL detach_ctrl_read: got %h expected %h", rd, 32'h8001_0001); end
        checks++;
        if (boot_sel !== 2'd1) begin errors++; $display("FAIL detach_sel_kept: got %0d expected 1", boot_sel); end
        // Land the abort commit on the edge where the counter holds 40.
        waits = c0 + 61 - cyc_n - 2;
        repeat (waits) @(posedge clk);
        bus(2'd0, 1'b1, ctrl_word(8'hB0, 1'b0, 2'd0), rd);
        checks++;
        if ({busy, usb_detach, boot} !== 3'b000) begin
            errors++; $display("FAIL abort_state: got busy/det/boot=%b expected 000", {busy, usb_detach, boot});
        end
        bus(2'd2, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL abort_count: got %0d expected 0", rd); end
        bus(2'd0, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'h0000_0001) begin errors++; $display("FAIL abort_ctrl_read: got %h expected %h", rd, 32'h1); end
        boot_seen = 0;
        repeat (120) begin @(posedge clk); #1; if (boot !== 1'b0) boot_seen++; end
        checks++;
        if (boot_seen != 0) begin errors++; $display("FAIL abort_no_boot: got %0d boot cycles expected 0", boot_seen); end
        bus(2'd1, 1'b1, 32'd9, rd);
        m_delay = 9;
        bus(2'd1, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== m_delay) begin errors++; $display("FAIL delay_after_abort: got %0d expected %0d", rd, m_delay); end
    endtask

    // Abort committed on the very edge the count would expire.
    task automatic test_abort_race(input int unsigned dly, input logic [1:0] sel);
        logic [31:0] rd;
        bus(2'd1, 1'b1, dly, rd);
        m_delay = dly;
        bus(2'd0, 1'b1, ctrl_word(8'hB0, 1'b1, sel), rd);
        m_sel = sel;
        repeat (m_delay - 1) @(posedge clk);
        bus(2'd0, 1'b1, ctrl_word(8'hB0, 1'b0, 2'd0), rd);
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({busy, usb_detach, boot, boot_sel} !== {3'b000, m_sel}) begin
            errors++;
            $display("FAIL abort_race d=%0d: got busy/det/boot/sel=%b expected %b",
                     dly, {busy, usb_detach, boot, boot_sel}, {3'b000, m_sel});
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        bad = 0;
        @(negedge clk);
        wb_addr = 2'd1; wb_we = 1'b0; wb_cyc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (wb_ack !== ((i % 2) == 0)) bad++;
            if (wb_rdata !== (((i % 2) == 0) ? m_delay : 32'd0)) bad++;
        end
        wb_cyc = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL back_to_back: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        bus(2'd1, 1'b1, 32'd3, rd);
        bus(2'd0, 1'b1, ctrl_word(8'hB0, 1'b1, 2'd2), rd);
        repeat (5) @(posedge clk); #1;
        checks++;
        if ({boot, usb_detach} !== 2'b11) begin
            errors++; $display("FAIL async_pre_boot: got boot/det=%b expected 11", {boot, usb_detach});
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({boot, usb_detach, busy, boot_sel, wb_ack} !== 6'b0) begin
            errors++;
            $display("FAIL async_drop: got boot/det/busy/sel/ack=%b expected 000000",
                     {boot, usb_detach, busy, boot_sel, wb_ack});
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        m_delay = DEF_DELAY;
        m_sel   = 2'b00;
        bus(2'd1, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== m_delay) begin errors++; $display("FAIL async_delay: got %0d expected %0d", rd, m_delay); end
        bus(2'd0, 1'b0, 32'd0, rd);
        checks++;
        if (rd !== 32'd0) begin errors++; $display("FAIL async_ctrl: got %h expected 0", rd); end
    endtask

    task automatic test_handshake_log();
        checks++;
        if (hs_bad != 0) begin errors++; $display("FAIL handshake: got %0d bad acks expected 0", hs_bad); end
    endtask

    initial begin
        test_reset();
        test_boot_seq(5, 2'd2);
        for (int i = 0; i < 3; i++) test_boot_seq($urandom_range(0, 12), 2'($urandom_range(0, 3)));
        test_bad_key();
        test_detach_ignore_abort();
        test_back_to_back();
        for (int i = 0; i < 3; i++) test_abort_race($urandom_range(1, 10), 2'($urandom_range(0, 3)));
        test_async_reset();
        test_handshake_log();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
